// File: rtl/decode_and_operand_fetch.sv
// Decode / operand-fetch stage: owns the 16x16 register file and a pending-write
// scoreboard, holds each issued op for EXEC_CYCLES. Optional macro: WB_BYPASS_EN.
module decode_and_operand_fetch #(
  parameter int EXEC_CYCLES = 3,
  parameter int NREGS       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instrValid,
  output logic        instrReady,
  output logic [3:0]  opcode,
  output logic [3:0]  destReg,
  output logic [15:0] srcVal1,
  output logic [15:0] srcVal2,
  output logic [7:0]  memAddr,
  output logic        used1,
  output logic        used2,
  input  logic [3:0]  destRegStore,
  input  logic [15:0] destVal,
  input  logic        storeNow,
  output logic        storeDone,
  input  logic        powerdown
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, STALL, HALT} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [7:0]  ma;
    logic        u1;
    logic        u2;
  } dec_t;

  localparam dec_t NOP_OUT = '{op: 4'd0, dst: 4'd0, s1: 16'd0, s2: 16'd0,
                               ma: 8'd0, u1: 1'b1, u2: 1'b1};

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  dec_t              out_q;
  logic              storeDone_q;
  logic [15:0]       regs_q [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;

  // Field decode
  logic [3:0]  op, fd, fs1, fs2, idx1;
  logic        rd1, rd2, wr, mem, nopish;
  logic [NREGS-1:0] clr_vec, src_pend;
  logic        hazard, can_issue;
  logic [15:0] opv1, opv2;
  dec_t        iss;

  assign op   = instr[15:12];
  assign fd   = instr[11:8];
  assign fs1  = instr[7:4];
  assign fs2  = instr[3:0];
  // STORE reads the register named in the dest field onto operand 1
  assign idx1 = (op == 4'd15) ? fd : fs1;

  always_comb begin
    rd1    = ((op >= 4'd1) && (op <= 4'd11)) || (op == 4'd15);
    rd2    = (op >= 4'd1) && (op <= 4'd7);
    wr     = ((op >= 4'd1) && (op <= 4'd11)) || (op == 4'd14);
    mem    = (op >= 4'd14);
    nopish = (op == 4'd0) || (op == 4'd12) || (op == 4'd13);
  end

  assign clr_vec = storeNow ? (NREGS'(1) << destRegStore) : '0;

`ifdef WB_BYPASS_EN
  assign src_pend = pending_q & ~clr_vec;
`else
  assign src_pend = pending_q;
`endif

  // WAW is checked against the raw pending bit; only sources may be forwarded
  assign hazard = (rd1 && src_pend[idx1]) || (rd2 && src_pend[fs2]) ||
                  (wr && pending_q[fd]);

  assign can_issue = !rst && !powerdown && instrValid && !hazard &&
                     ((state_q == IDLE) || (state_q == STALL) ||
                      ((state_q == HOLD) && (cnt_q == '0)));

  assign instrReady = can_issue;

  always_comb begin
    opv1 = regs_q[idx1];
    opv2 = regs_q[fs2];
`ifdef WB_BYPASS_EN
    if (storeNow && (destRegStore == idx1)) opv1 = destVal;
    if (storeNow && (destRegStore == fs2))  opv2 = destVal;
`endif
  end

  always_comb begin
    iss = NOP_OUT;
    if (!nopish) begin
      iss.op  = op;
      iss.dst = fd;
      iss.u1  = !rd1;
      iss.u2  = !rd2;
      iss.s1  = rd1 ? opv1 : 16'd0;
      iss.s2  = rd2 ? opv2 : 16'd0;
      iss.ma  = mem ? instr[7:0] : 8'd0;
    end
  end

  // Clear first, then set, so an issue to the register being retired keeps it pending
  always_comb begin
    pending_d = pending_q & ~clr_vec;
    if (can_issue && wr) pending_d[fd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      storeDone_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      pending_q   <= pending_d;
      storeDone_q <= storeNow;
      if (storeNow) regs_q[destRegStore] <= destVal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= NOP_OUT;
    end else if (powerdown) begin
      state_q <= HALT;
      out_q   <= NOP_OUT;
    end else begin
      case (state_q)
        IDLE, STALL: begin
          if (can_issue) begin
            out_q   <= iss;
            cnt_q   <= CW'(EXEC_CYCLES - 1);
            state_q <= HOLD;
          end else begin
            out_q   <= NOP_OUT;
            state_q <= instrValid ? STALL : IDLE;
          end
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (can_issue) begin
            out_q <= iss;
            cnt_q <= CW'(EXEC_CYCLES - 1);
          end else begin
            out_q   <= NOP_OUT;
            state_q <= instrValid ? STALL : IDLE;
          end
        end
        HALT:    out_q <= NOP_OUT;
        default: begin
          out_q   <= NOP_OUT;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign opcode    = out_q.op;
  assign destReg   = out_q.dst;
  assign srcVal1   = out_q.s1;
  assign srcVal2   = out_q.s2;
  assign memAddr   = out_q.ma;
  assign used1     = out_q.u1;
  assign used2     = out_q.u2;
  assign storeDone = storeDone_q;

endmodule

// File: tb/tb_decode_and_operand_fetch.sv
// Scoreboard bench for decode_and_operand_fetch: expected issue payloads are queued
// as instructions are driven and popped one cycle after instrReady is seen.
module tb_decode_and_operand_fetch;
  localparam int EC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = '0;
  logic        instrValid = 1'b0;
  logic        instrReady;
  logic [3:0]  opcode, destReg;
  logic [15:0] srcVal1, srcVal2;
  logic [7:0]  memAddr;
  logic        used1, used2;
  logic [3:0]  destRegStore = '0;
  logic [15:0] destVal = '0;
  logic        storeNow = 1'b0;
  logic        storeDone;
  logic        powerdown = 1'b0;

  decode_and_operand_fetch #(.EXEC_CYCLES(EC), .NREGS(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instrValid(instrValid),
    .instrReady(instrReady), .opcode(opcode), .destReg(destReg),
    .srcVal1(srcVal1), .srcVal2(srcVal2), .memAddr(memAddr),
    .used1(used1), .used2(used2), .destRegStore(destRegStore),
    .destVal(destVal), .storeNow(storeNow), .storeDone(storeDone),
    .powerdown(powerdown)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [7:0]  ma;
    logic        u1;
    logic        u2;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;
  logic pend_cmp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] dst, input logic [15:0] s1,
                      input logic [15:0] s2, input logic [7:0] ma, input logic u1,
                      input logic u2);
    exp_t e;
    e = '{op: op, dst: dst, s1: s1, s2: s2, ma: ma, u1: u1, u2: u2};
    q.push_back(e);
  endtask

  // Outputs appear on the edge after the cycle in which instrReady was high
  always @(negedge clk) begin
    exp_t e;
    if (pend_cmp) begin
      if (q.size() == 0) chk("q_underrun", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("opcode",  opcode,  e.op);
        chk("destReg", destReg, e.dst);
        chk("srcVal1", srcVal1, e.s1);
        chk("srcVal2", srcVal2, e.s2);
        chk("memAddr", memAddr, e.ma);
        chk("used1",   used1,   e.u1);
        chk("used2",   used2,   e.u2);
      end
    end
    pend_cmp <= instrReady;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wb(input logic [3:0] r, input logic [15:0] v);
    storeNow = 1'b1; destRegStore = r; destVal = v;
    cyc();
    storeNow = 1'b0;
    chk("storeDone", storeDone, 1'b1);
  endtask

  // Present w and wait (bounded) for it to be consumed; checks cycles waited
  task automatic issue(input logic [15:0] w, input int exp_wait, input string tag);
    int n;
    n = 0;
    instr = w; instrValid = 1'b1;
    #3;
    while (!instrReady && n < 20) begin
      @(posedge clk); #4;
      n++;
    end
    chk({tag, "_wait"}, n, exp_wait);
    @(posedge clk); #1;
    instrValid = 1'b0;
  endtask

  // Retire a pending register while a dependent instruction is stalled
  task automatic release_wb(input logic [3:0] r, input logic [15:0] v);
    storeNow = 1'b1; destRegStore = r; destVal = v;
    #3;
`ifdef WB_BYPASS_EN
    chk("bypass_rdy", instrReady, 1'b1);
`else
    chk("nobyp_rdy", instrReady, 1'b0);
`endif
    @(posedge clk); #1;
    storeNow = 1'b0;
`ifndef WB_BYPASS_EN
    #3;
    chk("rdy_after_clr", instrReady, 1'b1);
    @(posedge clk); #1;
`endif
    instrValid = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_opcode", opcode, 4'd0);
    chk("rst_used1", used1, 1'b1);
    chk("rst_used2", used2, 1'b1);
    chk("rst_ready", instrReady, 1'b0);
    chk("rst_sdone", storeDone, 1'b0);
    rst = 1'b0;
    cyc();

    wb(4'd1, 16'd24);
    wb(4'd2, 16'd30);
    wb(4'd3, 16'd45);

    // two-source ALU, held for EC cycles
    push(4'd2, 4'd12, 16'd24, 16'd30, 8'd0, 1'b0, 1'b0);
    issue(16'h2C12, 0, "t1");
    chk("hold0", opcode, 4'd2);
    cyc(); chk("hold1", opcode, 4'd2);
    cyc(); chk("hold2", opcode, 4'd2);
    cyc(); chk("hold_end", opcode, 4'd0);

    // RAW on r12 stalls until write-back
    instr = 16'h3DC0; instrValid = 1'b1;
    #3; chk("raw_stall0", instrReady, 1'b0);
    @(posedge clk); #4;
    chk("raw_stall1", instrReady, 1'b0);
    chk("raw_nop", opcode, 4'd0);
    @(posedge clk); #1;
    push(4'd3, 4'd13, 16'd54, 16'd0, 8'd0, 1'b0, 1'b0);
    release_wb(4'd12, 16'd54);
    repeat (EC) cyc();
    wb(4'd13, 16'd1);

    // write-back pulse, read-back, STORE, back-to-back issue
    wb(4'd5, 16'h1234);
    cyc(); chk("sd_pulse", storeDone, 1'b0);
    push(4'd8, 4'd6, 16'h1234, 16'd0, 8'd0, 1'b0, 1'b1);
    issue(16'h8650, 0, "rd_r5");
    push(4'd15, 4'd3, 16'd45, 16'd0, 8'hB4, 1'b0, 1'b1);
    issue(16'hF3B4, EC - 1, "store");
    push(4'd1, 4'd3, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0);
    issue(16'h1300, EC - 1, "after_st");
    repeat (EC) cyc();
    wb(4'd6, 16'd0);
    wb(4'd3, 16'd45);

    // storeNow held two cycles pulses twice
    storeNow = 1'b1; destRegStore = 4'd10; destVal = 16'd1;
    cyc(); chk("held_sd0", storeDone, 1'b1);
    destVal = 16'd2;
    cyc(); chk("held_sd1", storeDone, 1'b1);
    storeNow = 1'b0;
    cyc(); chk("held_sd2", storeDone, 1'b0);
    push(4'd8, 4'd11, 16'd2, 16'd0, 8'd0, 1'b0, 1'b1);
    issue(16'h8BA0, 0, "rd_r10");
    repeat (EC) cyc();

    // LOAD issued while r7 retires: set wins, reader of r7 stalls
    instr = 16'hE7B4; instrValid = 1'b1;
    storeNow = 1'b1; destRegStore = 4'd7; destVal = 16'd11;
    push(4'd14, 4'd7, 16'd0, 16'd0, 8'hB4, 1'b1, 1'b1);
    #3; chk("load_rdy", instrReady, 1'b1);
    @(posedge clk); #1;
    storeNow = 1'b0;
    instr = 16'h1870;
    repeat (6) begin
      #3; chk("setwins_stall", instrReady, 1'b0);
      @(posedge clk); #1;
    end
    push(4'd1, 4'd8, 16'h0055, 16'd0, 8'd0, 1'b0, 1'b0);
    release_wb(4'd7, 16'h0055);
    repeat (EC) cyc();
    wb(4'd8, 16'd0);

    // powerdown mid-HOLD
    push(4'd1, 4'd9, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0);
    issue(16'h1900, 0, "pre_halt");
    powerdown = 1'b1; instr = 16'h0000; instrValid = 1'b1;
    cyc();
    chk("halt_op", opcode, 4'd0);
    chk("halt_dst", destReg, 4'd0);
    chk("halt_u1", used1, 1'b1);
    repeat (4) begin
      #3; chk("halt_rdy", instrReady, 1'b0);
      @(posedge clk); #1;
    end
    instrValid = 1'b0;
    wb(4'd4, 16'h4444);
    rst = 1'b1;
    cyc();
    chk("rst2_op", opcode, 4'd0);
    chk("rst2_s1", srcVal1, 16'd0);
    chk("rst2_ma", memAddr, 8'd0);
    chk("rst2_u2", used2, 1'b1);
    chk("rst2_sd", storeDone, 1'b0);
    chk("rst2_rdy", instrReady, 1'b0);
    rst = 1'b0; powerdown = 1'b0;
    cyc();
    push(4'd1, 4'd9, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0);
    issue(16'h1999, 0, "post_rst_sb");
    push(4'd8, 4'd10, 16'd0, 16'd0, 8'd0, 1'b0, 1'b1);
    issue(16'h8A40, EC - 1, "post_rst_rf");
    repeat (EC + 1) cyc();
    chk("q_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
